// File: rtl/counter_seq_monitor_pkg.sv
// Shared state encoding and default sizing for the counter sequence monitor.
package counter_seq_monitor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_ACQUIRE = 2'b01,
        ST_LOCKED  = 2'b10
    } mon_state_e;

    localparam int unsigned DEF_WIDTH      = 4;
    localparam int unsigned DEF_LOCK_N     = 4;
    localparam int unsigned DEF_ERR_CNT_W  = 8;
    localparam int unsigned DEF_WRAP_CNT_W = 8;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous clear taking priority over increment.
module sat_counter
    import counter_seq_monitor_pkg::*;
#(
    parameter int unsigned W = DEF_ERR_CNT_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_d = W'(cnt_q + 1'b1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/counter_seq_monitor.sv
// Checks a free-running up counter for strict +1 steps, tracks lock and
// keeps saturating error/wrap statistics.
module counter_seq_monitor
    import counter_seq_monitor_pkg::*;
#(
    parameter int unsigned WIDTH      = DEF_WIDTH,
    parameter int unsigned LOCK_N     = DEF_LOCK_N,
    parameter int unsigned ERR_CNT_W  = DEF_ERR_CNT_W,
    parameter int unsigned WRAP_CNT_W = DEF_WRAP_CNT_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  clear,
    input  logic [WIDTH-1:0]      count_in,
    output logic [1:0]            state,
    output logic                  locked,
    output logic                  err_pulse,
    output logic                  err_sticky,
    output logic [ERR_CNT_W-1:0]  err_count,
    output logic                  wrap_pulse,
    output logic [WRAP_CNT_W-1:0] wrap_count
);

    localparam int unsigned RUN_W = $clog2(LOCK_N + 1);

    mon_state_e       state_q;
    mon_state_e       state_d;
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] prev_d;
    logic [WIDTH-1:0] expected;
    logic [RUN_W-1:0] run_q;
    logic [RUN_W-1:0] run_d;
    logic [RUN_W-1:0] run_inc;
    logic             match;
    logic             err_evt;
    logic             wrap_evt;
    logic             locked_q;
    logic             err_pulse_q;
    logic             wrap_pulse_q;
    logic             err_sticky_q;

    assign expected = WIDTH'(prev_q + 1'b1);
    assign match    = (count_in == expected);
    assign run_inc  = RUN_W'(run_q + 1'b1);

    // Next-state and event decode; the compare acts on the edge that samples count_in.
    always_comb begin
        state_d  = state_q;
        prev_d   = prev_q;
        run_d    = run_q;
        err_evt  = 1'b0;
        wrap_evt = 1'b0;
        case (state_q)
            ST_ACQUIRE: begin
                if (!en) begin
                    state_d = ST_IDLE;
                    run_d   = '0;
                end else begin
                    prev_d = count_in;
                    if (match) begin
                        run_d = run_inc;
                        if (run_inc == RUN_W'(LOCK_N)) begin
                            state_d = ST_LOCKED;
                        end
                    end else begin
                        run_d = '0;
                    end
                end
            end
            ST_LOCKED: begin
                if (!en) begin
                    state_d = ST_IDLE;
                    run_d   = '0;
                end else begin
                    prev_d = count_in;
                    if (match) begin
                        wrap_evt = (prev_q == {WIDTH{1'b1}});
                    end else begin
                        err_evt = 1'b1;
                        run_d   = '0;
                        state_d = ST_ACQUIRE;
                    end
                end
            end
            default: begin
                // IDLE, and the unused code which behaves as IDLE
                if (en) begin
                    prev_d  = count_in;
                    run_d   = '0;
                    state_d = ST_ACQUIRE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            prev_q       <= '0;
            run_q        <= '0;
            locked_q     <= 1'b0;
            err_pulse_q  <= 1'b0;
            wrap_pulse_q <= 1'b0;
            err_sticky_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            prev_q       <= prev_d;
            run_q        <= run_d;
            locked_q     <= (state_d == ST_LOCKED);
            err_pulse_q  <= err_evt;
            wrap_pulse_q <= wrap_evt;
            if (clear) begin
                err_sticky_q <= 1'b0;
            end else if (err_evt) begin
                err_sticky_q <= 1'b1;
            end
        end
    end

    sat_counter #(.W(ERR_CNT_W)) u_err_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (clear),
        .inc   (err_evt),
        .cnt   (err_count)
    );

    sat_counter #(.W(WRAP_CNT_W)) u_wrap_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (clear),
        .inc   (wrap_evt),
        .cnt   (wrap_count)
    );

    assign state      = state_q;
    assign locked     = locked_q;
    assign err_pulse  = err_pulse_q;
    assign wrap_pulse = wrap_pulse_q;
    assign err_sticky = err_sticky_q;

endmodule

// File: tb/tb_counter_seq_monitor.sv
// Scoreboard bench for counter_seq_monitor: stimulus pushes expected outputs, a monitor pops and compares.
module tb_counter_seq_monitor;

    localparam int unsigned WIDTH  = 4;
    localparam int unsigned LOCK_N = 4;
    localparam int unsigned ERR_W  = 2;
    localparam int unsigned WRAP_W = 8;
    localparam int unsigned ERR_MAX  = (1 << ERR_W) - 1;
    localparam int unsigned WRAP_MAX = (1 << WRAP_W) - 1;
    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_ACQ  = 2'b01;
    localparam logic [1:0] S_LCK  = 2'b10;

    logic              clk;
    logic              reset;
    logic              en;
    logic              clear;
    logic [WIDTH-1:0]  count_in;
    logic [1:0]        state;
    logic              locked;
    logic              err_pulse;
    logic              err_sticky;
    logic [ERR_W-1:0]  err_count;
    logic              wrap_pulse;
    logic [WRAP_W-1:0] wrap_count;

    counter_seq_monitor #(
        .WIDTH      (WIDTH),
        .LOCK_N     (LOCK_N),
        .ERR_CNT_W  (ERR_W),
        .WRAP_CNT_W (WRAP_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .clear      (clear),
        .count_in   (count_in),
        .state      (state),
        .locked     (locked),
        .err_pulse  (err_pulse),
        .err_sticky (err_sticky),
        .err_count  (err_count),
        .wrap_pulse (wrap_pulse),
        .wrap_count (wrap_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int sb_idx = 0;
    logic [15:0] sb_q[$];

    // Reference behaviour
    logic [1:0]       m_state;
    logic [WIDTH-1:0] m_prev;
    int               m_run;
    int unsigned      m_err;
    int unsigned      m_wrap;
    logic             m_sticky;
    logic             m_ep;
    logic             m_wp;

    task automatic model_reset();
        m_state = S_IDLE; m_prev = '0; m_run = 0; m_err = 0; m_wrap = 0;
        m_sticky = 1'b0; m_ep = 1'b0; m_wp = 1'b0;
    endtask

    task automatic model_step(input logic e, input logic c, input logic [WIDTH-1:0] v);
        logic good;
        logic [WIDTH-1:0] nxt;
        nxt  = m_prev + 4'd1;
        good = (v == nxt);
        m_ep = 1'b0;
        m_wp = 1'b0;
        if (!e) begin
            m_state = S_IDLE;
            m_run   = 0;
        end else if (m_state == S_IDLE) begin
            m_state = S_ACQ;
            m_run   = 0;
        end else if (!good) begin
            m_ep    = (m_state == S_LCK);
            m_state = S_ACQ;
            m_run   = 0;
        end else if (m_state == S_LCK) begin
            m_wp = (m_prev == 4'hF);
        end else begin
            m_run = m_run + 1;
            if (m_run == LOCK_N) m_state = S_LCK;
        end
        if (e) m_prev = v;
        if (c) begin
            m_err = 0; m_wrap = 0; m_sticky = 1'b0;
        end else begin
            if (m_ep) begin
                m_sticky = 1'b1;
                if (m_err < ERR_MAX) m_err = m_err + 1;
            end
            if (m_wp && m_wrap < WRAP_MAX) m_wrap = m_wrap + 1;
        end
    endtask

    function automatic logic [15:0] model_pack();
        return {m_state, (m_state == S_LCK), m_ep, m_sticky, ERR_W'(m_err), m_wp, WRAP_W'(m_wrap)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One clock of stimulus; returns after the edge has settled.
    task automatic cyc(input logic e, input logic c, input logic [WIDTH-1:0] v);
        @(negedge clk);
        en = e; clear = c; count_in = v;
        model_step(e, c, v);
        sb_q.push_back(model_pack());
        @(posedge clk);
        #2;
    endtask

    // Monitor: outputs are presented every edge; compare against the queued expectation.
    initial begin
        logic [15:0] act;
        logic [15:0] exp;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                exp = sb_q.pop_front();
                act = {state, locked, err_pulse, err_sticky, err_count, wrap_pulse, wrap_count};
                total++;
                if (act !== exp) begin
                    bad++;
                    $display("FAIL sb[%0d]: got %h expected %h", sb_idx, act, exp);
                end
                sb_idx++;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [WIDTH-1:0] cnt;
        reset = 1'b1; en = 1'b0; clear = 1'b0; count_in = '0;
        model_reset();
        #1;
        chk("reset_state", 32'(state), 0);
        chk("reset_locked", 32'(locked), 0);
        chk("reset_err_count", 32'(err_count), 0);
        chk("reset_wrap_count", 32'(wrap_count), 0);
        @(negedge clk);
        reset = 1'b0;

        // Lock acquire from 0
        cyc(1'b1, 1'b0, 4'd0);
        chk("acq_state", 32'(state), 1);
        for (int i = 1; i <= 3; i++) cyc(1'b1, 1'b0, 4'(i));
        chk("acq_not_locked_at_3", 32'(locked), 0);
        cyc(1'b1, 1'b0, 4'd4);
        chk("lock_at_4", 32'(locked), 1);
        chk("lock_state", 32'(state), 2);
        chk("lock_err_count", 32'(err_count), 0);

        // Wrap through 15 -> 0
        for (int i = 5; i <= 15; i++) cyc(1'b1, 1'b0, 4'(i));
        cyc(1'b1, 1'b0, 4'd0);
        chk("wrap_pulse", 32'(wrap_pulse), 1);
        chk("wrap_count_1", 32'(wrap_count), 1);
        cnt = 4'd0;
        for (int i = 0; i < 48; i++) begin
            cnt = cnt + 4'd1;
            cyc(1'b1, 1'b0, cnt);
        end
        chk("wrap_count_4", 32'(wrap_count), 4);
        chk("wrap_err_count", 32'(err_count), 0);

        // Fault injection: 1..5 then 9
        for (int i = 1; i <= 5; i++) cyc(1'b1, 1'b0, 4'(i));
        cyc(1'b1, 1'b0, 4'd9);
        chk("fault_err_pulse", 32'(err_pulse), 1);
        chk("fault_locked", 32'(locked), 0);
        chk("fault_err_count", 32'(err_count), 1);
        chk("fault_sticky", 32'(err_sticky), 1);
        for (int i = 10; i <= 12; i++) cyc(1'b1, 1'b0, 4'(i));
        chk("fault_err_pulse_gone", 32'(err_pulse), 0);
        chk("relock_not_at_12", 32'(locked), 0);
        cyc(1'b1, 1'b0, 4'd13);
        chk("relock_at_13", 32'(locked), 1);

        // Upstream counter reset while locked at 7
        cyc(1'b1, 1'b0, 4'd14);
        cyc(1'b1, 1'b0, 4'd15);
        for (int i = 0; i <= 7; i++) cyc(1'b1, 1'b0, 4'(i));
        chk("upstream_wrap_count", 32'(wrap_count), 5);
        cyc(1'b1, 1'b0, 4'd0);
        chk("upstream_err_count", 32'(err_count), 2);
        chk("upstream_locked", 32'(locked), 0);
        for (int i = 1; i <= 3; i++) cyc(1'b1, 1'b0, 4'(i));
        chk("upstream_not_locked_at_3", 32'(locked), 0);
        cyc(1'b1, 1'b0, 4'd4);
        chk("upstream_relock_at_4", 32'(locked), 1);

        // Saturation: five lock-then-fault rounds with a held value as the fault
        cnt = 4'd4;
        for (int r = 0; r < 5; r++) begin
            cyc(1'b1, 1'b0, cnt);
            for (int i = 0; i < 4; i++) begin
                cnt = cnt + 4'd1;
                cyc(1'b1, 1'b0, cnt);
            end
        end
        chk("sat_err_count", 32'(err_count), 3);
        chk("sat_locked", 32'(locked), 1);

        // Clear together with the sixth error
        cnt = cnt + 4'd7;
        cyc(1'b1, 1'b1, cnt);
        chk("clr_err_pulse", 32'(err_pulse), 1);
        chk("clr_err_count", 32'(err_count), 0);
        chk("clr_sticky", 32'(err_sticky), 0);
        chk("clr_wrap_count", 32'(wrap_count), 0);
        for (int i = 0; i < 4; i++) begin
            cnt = cnt + 4'd1;
            cyc(1'b1, 1'b0, cnt);
        end
        cyc(1'b1, 1'b0, cnt);
        chk("post_clr_err_count", 32'(err_count), 1);

        // Enable low forces IDLE, statistics hold
        cyc(1'b0, 1'b0, 4'd3);
        chk("en_off_state", 32'(state), 0);
        chk("en_off_locked", 32'(locked), 0);
        chk("en_off_err_count", 32'(err_count), 1);
        cyc(1'b0, 1'b0, 4'd9);
        chk("en_off_pulse", 32'(err_pulse), 0);

        // Relock, then asynchronous reset between edges
        for (int i = 0; i <= 4; i++) cyc(1'b1, 1'b0, 4'(i));
        chk("pre_reset_locked", 32'(locked), 1);
        for (int i = 0; i < 5 && sb_q.size() > 0; i++) @(posedge clk);
        if (sb_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL sb_drain: got %0d pending expected 0", sb_q.size());
        end
        @(negedge clk);
        en = 1'b1; count_in = 4'd5;
        #1;
        reset = 1'b1;
        #1;
        chk("async_reset_state", 32'(state), 0);
        chk("async_reset_locked", 32'(locked), 0);
        chk("async_reset_err_count", 32'(err_count), 0);
        chk("async_reset_sticky", 32'(err_sticky), 0);
        chk("async_reset_wrap_count", 32'(wrap_count), 0);
        model_reset();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/counter_seq_monitor.md
Name: counter_seq_monitor

Overview:
- Downstream checker for the 4-bit ripple-style up counter; samples its q bus every clk.
- Verifies the strict +1 mod 2^WIDTH sequence and acquires/loses lock.
- Counts sequence errors and wrap-arounds for status readout and cocotb checking.
- Sits directly on the counter output, in the same clock domain, with no synchroniser.

Parameters:
- WIDTH, 4, width of the monitored count bus.
- LOCK_N, 4, consecutive correct increments required to declare lock (>=1).
- ERR_CNT_W, 8, width of the saturating error counter.
- WRAP_CNT_W, 8, width of the saturating wrap counter.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  reset, asynchronous, active-high.
- en  in  1  monitor enable; low forces IDLE.
- clear  in  1  synchronous clear of statistics (err_count, wrap_count, err_sticky).
- count_in  in  WIDTH  counter value under observation.
- state  out  2  current FSM state code.
- locked  out  1  high while state is LOCKED.
- err_pulse  out  1  one-cycle pulse per sequence error detected while LOCKED.
- err_sticky  out  1  set by any error; cleared only by reset or clear.
- err_count  out  ERR_CNT_W  saturating count of errors.
- wrap_pulse  out  1  one-cycle pulse on a valid all-ones to zero step while LOCKED.
- wrap_count  out  WRAP_CNT_W  saturating count of wraps.

Behaviour:
- Reset (async) values:
  - state=IDLE; locked=0; err_pulse=0; err_sticky=0; err_count=0; wrap_pulse=0; wrap_count=0.
  - Internal registers: prev=0, run=0.
- Internal registers:
  - prev: WIDTH bits.
  - run: $clog2(LOCK_N+1) bits.
  - expected = prev+1, truncated to WIDTH (natural wrap).
- All outputs are registered. Comparison is combinational on count_in vs expected; results take effect at the same edge that samples count_in. Zero added latency.
- IDLE:
  - en=0: hold. prev, run and stats unchanged.
  - en=1: prev<=count_in, run<=0, go ACQUIRE. The first sample is never compared.
- ACQUIRE, en=1:
  - prev<=count_in on every edge.
  - match: run<=run+1. If run+1==LOCK_N, go LOCKED (locked=1 from that edge).
  - mismatch: run<=0, stay. No error is counted.
- LOCKED, en=1:
  - prev<=count_in on every edge.
  - match: stay. If prev==all-ones (so count_in==0): wrap_pulse=1 and wrap_count increments.
  - mismatch: err_pulse=1, err_sticky<=1, err_count increments, run<=0, go ACQUIRE. locked drops at that same edge.
- en=0 in any state: go IDLE at the next edge.
  - locked=0 and run=0.
  - Pulses are low.
  - Statistics hold.
- Pulses: err_pulse and wrap_pulse are high for exactly one cycle per event and low otherwise.
- Saturation: err_count and wrap_count stick at all-ones and never roll over.
- clear:
  - Zeros err_count, wrap_count and err_sticky. Does not affect state, prev, run or pulses.
  - clear and an event in the same cycle: clear wins for counters/sticky; the pulse still fires.
- Upstream counter reset mid-run (count jumps to 0 from a non-all-ones value) is a normal mismatch and is counted if LOCKED.
- Reset mid-operation returns to reset values immediately, independent of clk.
- Held or stuck count_in (repeat value) is a mismatch.

Decomposition:
- Package counter_seq_monitor_pkg:
  - State encoding IDLE=2'b00, ACQUIRE=2'b01, LOCKED=2'b10 (2'b11 unused; decodes to IDLE).
  - Default parameter constants.
- One sub-module sat_counter (parameter W; inputs clk, reset, clr, inc; output cnt).
  - clr has priority over inc.
  - Instantiated twice, for err_count and wrap_count.

Test Plan:
- Reset: assert reset with en=1 and count_in=5 -> all outputs 0, state=2'b00 with no clk edge required.
- Lock acquire: en=1, counter from 0 (edges sample 0,1,2,3,4) -> state=ACQUIRE after sample 0; locked=1 at the edge sampling 4; err_count=0.
- Wrap: keep running from lock through 15->0 -> wrap_pulse high one cycle at the sample of 0, wrap_count=1; after 48 more cycles wrap_count=4, err_count=0.
- Fault injection: while locked, force 5 then 9 -> err_pulse one cycle and locked=0 at the sample of 9; err_count=1, err_sticky=1; relocks (locked=1) at the sample of 13 via 10,11,12,13.
- Upstream reset: while locked at 7, counter reset -> sample 0 -> err_count increments by 1; relock at sample 4.
- Saturation, clear and enable (ERR_CNT_W=2): 5 lock-then-fault cycles -> err_count stays 3.
  - clear asserted in the same cycle as the 6th error -> err_count=0 and err_sticky=0 while err_pulse=1.
  - en=0 -> IDLE next edge, locked=0, err_count holds.
